// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states, owner IDs and wait-counter width.
package mem_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_DATA  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus SRAM pins; slave = arbiter side, master = requesters and memory.
interface mem_port_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ack;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ack;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ce;
   logic              mem_oe;
   logic              mem_we;
   logic              busy;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack,
             mem_addr, mem_wdata, mem_ce, mem_oe, mem_we, busy
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack,
             mem_addr, mem_wdata, mem_ce, mem_oe, mem_we, busy
   );

endinterface

// File: rtl/mem_port_arbiter_wait_counter.sv
// Load/decrement wait-state counter with a registered zero flag.
module mem_wait_counter
   import mem_arb_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             zero_q, zero_d;

   always_comb begin
      cnt_d  = cnt_q;
      zero_d = zero_q;
      if (load_i) begin
         cnt_d  = LOAD_VAL;
         zero_d = (LOAD_VAL == '0);
      end else if (dec_i && !zero_q) begin
         cnt_d  = cnt_q - CNT_W'(1);
         zero_d = (cnt_q == CNT_W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         zero_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign zero_o = zero_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between instruction fetch and data load/store.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);

   arb_state_e        state_q, state_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] if_rd_q, if_rd_d;
   logic [DATA_W-1:0] d_rd_q, d_rd_d;
   logic              ce_q, ce_d;
   logic              oe_q, oe_d;
   logic              mwe_q, mwe_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic              busy_q, busy_d;
   logic              cnt_load_c, cnt_dec_c, cnt_zero;

   mem_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
      .clk    (clk),
      .rst    (rst),
      .load_i (cnt_load_c),
      .dec_i  (cnt_dec_c),
      .zero_o (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      if_rd_d    = if_rd_q;
      d_rd_d     = d_rd_q;
      cnt_load_c = 1'b0;
      cnt_dec_c  = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.if_req || bus.d_req) begin
               // Data wins unless fetch also asks and data had the last grant
               if (bus.d_req && (!bus.if_req || last_q == OWN_FETCH)) begin
                  owner_d = OWN_DATA;
                  we_d    = bus.d_we;
                  addr_d  = bus.d_addr;
                  wdata_d = bus.d_we ? bus.d_wdata : '0;
               end else begin
                  owner_d = OWN_FETCH;
                  we_d    = 1'b0;
                  addr_d  = bus.if_addr;
                  wdata_d = '0;
               end
               last_d  = owner_d;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_load_c = 1'b1;
            state_d    = ACCESS;
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = DONE;
               if (!we_q) begin
                  if (owner_q == OWN_DATA) d_rd_d  = bus.mem_rdata;
                  else                     if_rd_d = bus.mem_rdata;
               end
            end else begin
               cnt_dec_c = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
         end
         default: state_d = IDLE;
      endcase

      // Pin and ack registers track the state being entered
      ce_d     = (state_d == SETUP) || (state_d == ACCESS);
      oe_d     = (state_d == ACCESS) && !we_d;
      mwe_d    = (state_d == ACCESS) && we_d;
      if_ack_d = (state_d == DONE) && (owner_d == OWN_FETCH);
      d_ack_d  = (state_d == DONE) && (owner_d == OWN_DATA);
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q  <= OWN_FETCH;
         last_q   <= OWN_FETCH;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         if_rd_q  <= '0;
         d_rd_q   <= '0;
         ce_q     <= 1'b0;
         oe_q     <= 1'b0;
         mwe_q    <= 1'b0;
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         owner_q  <= owner_d;
         last_q   <= last_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         if_rd_q  <= if_rd_d;
         d_rd_q   <= d_rd_d;
         ce_q     <= ce_d;
         oe_q     <= oe_d;
         mwe_q    <= mwe_d;
         if_ack_q <= if_ack_d;
         d_ack_q  <= d_ack_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_ce    = ce_q;
   assign bus.mem_oe    = oe_q;
   assign bus.mem_we    = mwe_q;
   assign bus.if_rdata  = if_rd_q;
   assign bus.d_rdata   = d_rd_q;
   assign bus.if_ack    = if_ack_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized rounds against a round-robin model.
module tb_mem_port_arbiter;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned W1 = 1;
   localparam int unsigned W3 = 3;

   logic clk = 1'b0;
   logic rst;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W1)) dut1 (
      .clk (clk), .rst (rst), .bus (b1.slave));
   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W3)) dut3 (
      .clk (clk), .rst (rst), .bus (b3.slave));

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic          use_pat;
   logic [DW-1:0] fix_rd1, fix_rd3;
   logic          m_last_data;   // model: 1 if data holds the last grant
   logic [DW-1:0] exp_if_rd, exp_d_rd;

   // Memory contents as seen by the data pins: a fixed word or an address-derived pattern
   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
      return {a[7:0], a[15:8]} ^ 16'h5A3C;
   endfunction

   assign b1.mem_rdata = use_pat ? pat(b1.mem_addr) : fix_rd1;
   assign b3.mem_rdata = fix_rd3;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      b1.if_req = 1'b0; b1.if_addr = '0; b1.d_req = 1'b0; b1.d_we = 1'b0;
      b1.d_addr = '0;   b1.d_wdata = '0;
      b3.if_req = 1'b0; b3.if_addr = '0; b3.d_req = 1'b0; b3.d_we = 1'b0;
      b3.d_addr = '0;   b3.d_wdata = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      tick();
      tick();
      rst = 1'b0;
      tick();
      m_last_data = 1'b0;
      exp_if_rd   = '0;
      exp_d_rd    = '0;
   endtask

   task automatic test_reset();
      int acks;
      rst = 1'b1;
      clear_in();
      use_pat = 1'b0;
      fix_rd1 = '0;
      fix_rd3 = '0;
      tick();
      checks++;
      if ({b1.mem_ce, b1.mem_oe, b1.mem_we, b1.busy, b1.if_ack, b1.d_ack} !== 6'b0)
         $display("FAIL reset_ctrl: got %b want 000000",
                  {b1.mem_ce, b1.mem_oe, b1.mem_we, b1.busy, b1.if_ack, b1.d_ack});
      checks++;
      if ({b1.mem_addr, b1.mem_wdata, b1.if_rdata, b1.d_rdata} !== 64'h0)
         $display("FAIL reset_data: got %h want 0",
                  {b1.mem_addr, b1.mem_wdata, b1.if_rdata, b1.d_rdata});
      if (errors == 0 && checks == 2) ; // keep going regardless
      rst = 1'b0;
      tick();
      b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 16'h0010; b1.d_wdata = 16'hCAFE;
      tick();
      tick();
      checks++;
      if (b1.mem_we !== 1'b1 || b1.mem_addr !== 16'h0010) begin
         errors++;
         $display("FAIL reset_pre_access: we=%b addr=%h want we=1 addr=0010", b1.mem_we, b1.mem_addr);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({b1.mem_we, b1.mem_ce, b1.busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_async: we/ce/busy=%b want 000", {b1.mem_we, b1.mem_ce, b1.busy});
      end
      b1.d_req = 1'b0;
      tick();
      rst = 1'b0;
      acks = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (b1.if_ack || b1.d_ack || b1.busy) acks++;
      end
      checks++;
      if (acks != 0) begin
         errors++;
         $display("FAIL reset_no_ack: busy/ack cycles=%0d want 0", acks);
      end
      m_last_data = 1'b0;
      exp_if_rd   = '0;
      exp_d_rd    = '0;
   endtask

   task automatic test_single_fetch();
      use_pat = 1'b0;
      fix_rd1 = 16'h6908;
      b1.if_req = 1'b1; b1.if_addr = 16'h0004;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({b1.mem_ce, b1.mem_oe, b1.mem_we} !== {(k == 1 || k == 2), (k == 2), 1'b0}) begin
            errors++;
            $display("FAIL fetch_pins c%0d: ce/oe/we=%b", k, {b1.mem_ce, b1.mem_oe, b1.mem_we});
         end
         checks++;
         if ({b1.if_ack, b1.d_ack} !== {(k == 3), 1'b0}) begin
            errors++;
            $display("FAIL fetch_ack c%0d: if_ack=%b d_ack=%b want %b 0", k, b1.if_ack, b1.d_ack, (k == 3));
         end
         if (k == 2) begin
            checks++;
            if (b1.mem_addr !== 16'h0004) begin
               errors++;
               $display("FAIL fetch_addr: got %h want 0004", b1.mem_addr);
            end
         end
         if (k == 3) b1.if_req = 1'b0;
      end
      fix_rd1 = 16'h0000;
      tick();
      tick();
      checks++;
      if (b1.if_rdata !== 16'h6908) begin
         errors++;
         $display("FAIL fetch_rdata_hold: got %h want 6908", b1.if_rdata);
      end
      m_last_data = 1'b0;
      exp_if_rd   = 16'h6908;
   endtask

   task automatic test_store();
      int we_cnt = 0;
      b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 16'h1234; b1.d_wdata = 16'hBEEF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (b1.mem_we) begin
            we_cnt++;
            checks++;
            if (b1.mem_addr !== 16'h1234 || b1.mem_wdata !== 16'hBEEF || b1.mem_oe !== 1'b0) begin
               errors++;
               $display("FAIL store_bus: addr=%h wdata=%h oe=%b want 1234 beef 0",
                        b1.mem_addr, b1.mem_wdata, b1.mem_oe);
            end
         end
         checks++;
         if ({b1.d_ack, b1.if_ack} !== {(k == 3), 1'b0}) begin
            errors++;
            $display("FAIL store_ack c%0d: d_ack=%b if_ack=%b", k, b1.d_ack, b1.if_ack);
         end
         if (k == 3) begin b1.d_req = 1'b0; b1.d_we = 1'b0; end
         if (k == 4) begin
            checks++;
            if (b1.mem_addr !== '0 || b1.mem_wdata !== '0) begin
               errors++;
               $display("FAIL store_idle_bus: addr=%h wdata=%h want 0 0", b1.mem_addr, b1.mem_wdata);
            end
         end
      end
      checks++;
      if (we_cnt != 1) begin
         errors++;
         $display("FAIL store_we_cycles: got %0d want 1", we_cnt);
      end
      checks++;
      if (b1.d_rdata !== exp_d_rd) begin
         errors++;
         $display("FAIL store_rdata: got %h want %h", b1.d_rdata, exp_d_rd);
      end
      m_last_data = 1'b1;
   endtask

   task automatic test_tie();
      logic got [4];
      int   n = 0, both = 0, cd = 0, cf = 0;
      logic r_d = 1'b0, r_f = 1'b0;
      do_reset();
      use_pat = 1'b0;
      fix_rd1 = 16'h7777;
      b1.d_we = 1'b1; b1.d_addr = 16'h0020; b1.d_wdata = 16'h5555; b1.if_addr = 16'h0030;
      b1.d_req = 1'b1; b1.if_req = 1'b1;
      for (int c = 0; c < 60 && n < 4; c++) begin
         tick();
         if (r_d) begin b1.d_req = 1'b1; r_d = 1'b0; end
         if (r_f) begin b1.if_req = 1'b1; r_f = 1'b0; end
         if (b1.if_ack && b1.d_ack) both++;
         if (b1.d_ack && n < 4) begin
            got[n] = 1'b1; n++; cd++;
            b1.d_req = 1'b0;
            r_d = (cd < 2);
         end else if (b1.if_ack && n < 4) begin
            got[n] = 1'b0; n++; cf++;
            b1.if_req = 1'b0;
            r_f = (cf < 2);
         end
      end
      checks++;
      if (n != 4) begin
         errors++;
         $display("FAIL tie_timeout: acks=%0d want 4", n);
      end
      // Data wins the first tie after reset, then grants alternate
      for (int i = 0; i < n; i++) begin
         checks++;
         if (got[i] !== ((i % 2) == 0)) begin
            errors++;
            $display("FAIL tie_order[%0d]: got data=%b want %b", i, got[i], ((i % 2) == 0));
         end
      end
      checks++;
      if (both != 0) begin
         errors++;
         $display("FAIL tie_simultaneous: got %0d cycles want 0", both);
      end
      clear_in();
      tick();
      m_last_data = 1'b0;
      exp_if_rd   = 16'h7777;
   endtask

   task automatic test_wait3();
      int oe_cnt = 0, ce_cnt = 0;
      fix_rd3 = 16'h1A2B;
      b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 16'h00FF;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (b3.mem_oe) oe_cnt++;
         if (b3.mem_ce) ce_cnt++;
         checks++;
         if (b3.d_ack !== (k == 5)) begin
            errors++;
            $display("FAIL w3_ack c%0d: got %b want %b", k, b3.d_ack, (k == 5));
         end
         if (k == 3) begin
            checks++;
            if (b3.mem_addr !== 16'h00FF) begin
               errors++;
               $display("FAIL w3_addr: got %h want 00ff", b3.mem_addr);
            end
         end
         if (k == 5) b3.d_req = 1'b0;
      end
      checks++;
      if (oe_cnt != 3 || ce_cnt != 4) begin
         errors++;
         $display("FAIL w3_pins: oe cycles=%0d ce cycles=%0d want 3 4", oe_cnt, ce_cnt);
      end
      checks++;
      if (b3.d_rdata !== 16'h1A2B) begin
         errors++;
         $display("FAIL w3_rdata: got %h want 1a2b", b3.d_rdata);
      end
   endtask

   task automatic test_protocol();
      use_pat = 1'b1;
      b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 16'h0042;
      for (int k = 1; k <= 4; k++) begin
         tick();
         if (k == 1) begin b1.d_req = 1'b0; b1.d_addr = 16'hFFFF; b1.d_we = 1'b1; end
         if (k == 2) begin
            checks++;
            if (b1.mem_addr !== 16'h0042 || b1.mem_oe !== 1'b1) begin
               errors++;
               $display("FAIL drop_addr: addr=%h oe=%b want 0042 1", b1.mem_addr, b1.mem_oe);
            end
         end
         checks++;
         if (b1.d_ack !== (k == 3)) begin
            errors++;
            $display("FAIL drop_ack c%0d: got %b want %b", k, b1.d_ack, (k == 3));
         end
      end
      exp_d_rd    = pat(16'h0042);
      m_last_data = 1'b1;
      checks++;
      if (b1.d_rdata !== exp_d_rd) begin
         errors++;
         $display("FAIL drop_rdata: got %h want %h", b1.d_rdata, exp_d_rd);
      end
      b1.d_we = 1'b0;
      b1.if_req = 1'b1; b1.if_addr = 16'h0100;
      for (int k = 1; k <= 8; k++) begin
         tick();
         checks++;
         if (b1.if_ack !== (k == 3 || k == 7)) begin
            errors++;
            $display("FAIL held_ack c%0d: got %b want %b", k, b1.if_ack, (k == 3 || k == 7));
         end
         if (k == 4 || k == 5) begin
            checks++;
            if (b1.busy !== (k == 5)) begin
               errors++;
               $display("FAIL held_busy c%0d: got %b want %b", k, b1.busy, (k == 5));
            end
         end
         if (k == 7) b1.if_req = 1'b0;
      end
      exp_if_rd   = pat(16'h0100);
      m_last_data = 1'b0;
      checks++;
      if (b1.if_rdata !== exp_if_rd) begin
         errors++;
         $display("FAIL held_rdata: got %h want %h", b1.if_rdata, exp_if_rd);
      end
   endtask

   task automatic test_random();
      logic [1:0]    mask;
      logic          f, d, dw, first_data, is_d, e_we;
      logic [AW-1:0] fa, da, e_addr;
      logic [DW-1:0] dd, e_wd;
      int            n_t;
      use_pat = 1'b1;
      for (int r = 0; r < 40; r++) begin
         tick();
         mask = 2'($urandom_range(1, 3));
         f    = mask[0];
         d    = mask[1];
         fa   = 16'($urandom);
         da   = 16'($urandom);
         dd   = 16'($urandom);
         dw   = 1'($urandom_range(0, 1));
         b1.if_req = f; b1.if_addr = fa;
         b1.d_req  = d; b1.d_we = dw; b1.d_addr = da; b1.d_wdata = dd;
         n_t        = int'(f) + int'(d);
         first_data = d && (!f || !m_last_data);
         for (int t = 0; t < n_t; t++) begin
            is_d = (t == 0) ? first_data : !first_data;
            if (t == 1) begin
               tick();
               checks++;
               if (b1.busy !== 1'b0 || b1.mem_ce !== 1'b0) begin
                  errors++;
                  $display("FAIL rnd_gap r%0d: busy=%b ce=%b want 0 0", r, b1.busy, b1.mem_ce);
               end
            end
            e_we   = is_d && dw;
            e_addr = is_d ? da : fa;
            e_wd   = e_we ? dd : '0;
            m_last_data = is_d;
            for (int k = 1; k <= int'(W1) + 2; k++) begin
               tick();
               if (k == 1) begin
                  checks++;
                  if ({b1.mem_ce, b1.mem_oe, b1.mem_we, b1.busy} !== 4'b1001) begin
                     errors++;
                     $display("FAIL rnd_setup r%0d: ce/oe/we/busy=%b want 1001", r,
                              {b1.mem_ce, b1.mem_oe, b1.mem_we, b1.busy});
                  end
               end else if (k <= int'(W1) + 1) begin
                  checks++;
                  if ({b1.mem_ce, b1.mem_oe, b1.mem_we} !== {1'b1, !e_we, e_we} ||
                      b1.mem_addr !== e_addr || b1.mem_wdata !== e_wd) begin
                     errors++;
                     $display("FAIL rnd_access r%0d: ce/oe/we=%b addr=%h wd=%h want %b %h %h", r,
                              {b1.mem_ce, b1.mem_oe, b1.mem_we}, b1.mem_addr, b1.mem_wdata,
                              {1'b1, !e_we, e_we}, e_addr, e_wd);
                  end
               end else begin
                  if (!e_we) begin
                     if (is_d) exp_d_rd  = pat(e_addr);
                     else      exp_if_rd = pat(e_addr);
                  end
                  checks++;
                  if ({b1.if_ack, b1.d_ack, b1.mem_ce} !== {!is_d, is_d, 1'b0}) begin
                     errors++;
                     $display("FAIL rnd_ack r%0d: if_ack/d_ack/ce=%b want %b", r,
                              {b1.if_ack, b1.d_ack, b1.mem_ce}, {!is_d, is_d, 1'b0});
                  end
                  checks++;
                  if (b1.if_rdata !== exp_if_rd || b1.d_rdata !== exp_d_rd) begin
                     errors++;
                     $display("FAIL rnd_rdata r%0d: if=%h d=%h want %h %h", r,
                              b1.if_rdata, b1.d_rdata, exp_if_rd, exp_d_rd);
                  end
                  if (is_d) b1.d_req = 1'b0;
                  else      b1.if_req = 1'b0;
               end
            end
         end
      end
      clear_in();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      m_last_data = 1'b0;
      exp_if_rd   = '0;
      exp_d_rd    = '0;
      test_reset();
      test_single_fetch();
      test_store();
      test_tie();
      test_wait3();
      test_protocol();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
